// File: rtl/digit_scan_capture.sv
// Receive-side monitor for a multiplexed 4-digit display bus: decodes active-low
// digit enables, captures dwell-qualified segment patterns and emits whole frames.
module digit_scan_capture #(
  parameter int SEG_W  = 8,
  parameter int SETTLE = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         ct,
  input  logic [SEG_W-1:0]   leds,
  output logic [1:0]         digit,
  output logic               digit_valid,
  output logic [4*SEG_W-1:0] frame,
  output logic               frame_valid,
  output logic               err,
  output logic [7:0]         err_count
);

  // {legal, index}; idle and multi-low patterns both decode to 3'b000
  function automatic logic [2:0] decode_ct(input logic [3:0] c);
    case (c)
      4'b1110: decode_ct = 3'b100;
      4'b1101: decode_ct = 3'b101;
      4'b1011: decode_ct = 3'b110;
      4'b0111: decode_ct = 3'b111;
      default: decode_ct = 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [3:0]                ct_p0;
  logic [SEG_W-1:0]          leds_p0;
  logic [3+SEG_W:0]          prev_p1;
  logic [3:0]                cnt_p1;
  logic [3:0]                seen_p1;
  logic [3:0][SEG_W-1:0]     slot_p1;

  logic [2:0]                dec_p0;
  logic                      same_p0;
  logic                      accept_p0;
  logic                      acc_legal;
  logic                      acc_illegal;
  logic [3:0]                seen_nx;
  logic [3:0][SEG_W-1:0]     frame_nx;

  // Stage p0 -> p1: dwell qualification and capture decisions
  always_comb begin
    dec_p0      = decode_ct(ct_p0);
    same_p0     = ({ct_p0, leds_p0} == prev_p1);
    accept_p0   = same_p0 && (cnt_p1 == 4'(SETTLE - 1));
    acc_legal   = accept_p0 && dec_p0[2];
    acc_illegal = accept_p0 && !dec_p0[2] && (ct_p0 != 4'hF);
    seen_nx     = seen_p1 | (4'b0001 << dec_p0[1:0]);
    frame_nx    = slot_p1;
    frame_nx[dec_p0[1:0]] = leds_p0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ct_p0       <= '0;
      leds_p0     <= '0;
      prev_p1     <= '0;
      cnt_p1      <= '0;
      seen_p1     <= '0;
      slot_p1     <= '0;
      digit       <= '0;
      digit_valid <= 1'b0;
      frame       <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
      err_count   <= '0;
    end else begin
      // Stage p0: pin sampling
      ct_p0       <= ct;
      leds_p0     <= leds;
      // Stage p1: history, decode, dwell, capture
      prev_p1     <= {ct_p0, leds_p0};
      digit       <= dec_p0[1:0];
      digit_valid <= dec_p0[2];

      if (!same_p0)
        cnt_p1 <= '0;
      else if (cnt_p1 != 4'(SETTLE))
        cnt_p1 <= cnt_p1 + 4'd1;

      frame_valid <= 1'b0;
      err         <= 1'b0;
      if (acc_legal) begin
        slot_p1[dec_p0[1:0]] <= leds_p0;
        if (seen_nx == 4'hF) begin
          frame       <= frame_nx;
          frame_valid <= 1'b1;
          seen_p1     <= '0;
        end else begin
          seen_p1 <= seen_nx;
        end
      end else if (acc_illegal) begin
        err       <= 1'b1;
        err_count <= sat_inc(err_count);
        seen_p1   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_digit_scan_capture.sv
// Self-checking bench for digit_scan_capture: step table plus hand sequences,
// with a frame scoreboard popped whenever frame_valid pulses.
module tb_digit_scan_capture;

  localparam int SEG_W = 8;
  localparam logic [3:0] D0 = 4'b1110, D1 = 4'b1101, D2 = 4'b1011, D3 = 4'b0111;
  localparam logic [3:0] IDLE = 4'b1111, ILL = 4'b1100, ILL2 = 4'b0011;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [3:0]        ct = 4'hF;
  logic [SEG_W-1:0]  leds = '0;
  logic [1:0]        digit;
  logic              digit_valid;
  logic [4*SEG_W-1:0] frame;
  logic              frame_valid;
  logic              err;
  logic [7:0]        err_count;

  digit_scan_capture #(.SEG_W(SEG_W), .SETTLE(4)) dut (
    .clk(clk), .reset(reset), .ct(ct), .leds(leds),
    .digit(digit), .digit_valid(digit_valid),
    .frame(frame), .frame_valid(frame_valid),
    .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [3:0]  c;
    logic [7:0]  l;
    int          hold;
    bit          fv;
    logic [31:0] fr;
    logic [1:0]  d;
    bit          dv;
    logic [7:0]  ec;
  } step_t;

  step_t       tbl[$];
  logic [31:0] exp_q[$];
  int checks = 0, errors = 0;
  int err_pulses = 0, fv_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic step_t mk(bit r, logic [3:0] c, logic [7:0] l, int h, bit fv,
                               logic [31:0] fr, logic [1:0] d, bit dv, logic [7:0] ec);
    step_t s;
    s.rst = r; s.c = c; s.l = l; s.hold = h; s.fv = fv;
    s.fr = fr; s.d = d; s.dv = dv; s.ec = ec;
    return s;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_digit"}, 32'(digit), 0);
    chk({tag, "_digit_valid"}, 32'(digit_valid), 0);
    chk({tag, "_frame"}, frame, 0);
    chk({tag, "_frame_valid"}, 32'(frame_valid), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_err_count"}, 32'(err_count), 0);
  endtask

  // Called at posedge+1; inputs are seen by exactly 'hold' rising edges.
  task automatic drive(input logic [3:0] c, input logic [7:0] l, input int hold);
    ct = c;
    leds = l;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    check_zero("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Scoreboard side: every frame pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (!reset) begin
      if (err) err_pulses++;
      if (frame_valid) begin
        fv_pulses++;
        chk("fv_err_overlap", 32'(err), 0);
        if (exp_q.size() == 0)
          chk("unexpected_frame_valid", 32'(frame_valid), 0);
        else
          chk("frame", frame, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int base, fvb;

    // mid-frame reset clears seen
    tbl.push_back(mk(0, D0, 8'h11, 8, 0, 0, 2'd0, 1, 0));
    tbl.push_back(mk(0, D1, 8'h22, 8, 0, 0, 2'd1, 1, 0));
    tbl.push_back(mk(1, D2, 8'h33, 8, 0, 0, 2'd2, 1, 0));
    tbl.push_back(mk(0, D3, 8'h44, 8, 0, 0, 2'd3, 1, 0));
    tbl.push_back(mk(0, D0, 8'h55, 8, 0, 0, 2'd0, 1, 0));
    tbl.push_back(mk(0, D1, 8'h66, 8, 1, 32'h44336655, 2'd1, 1, 0));
    // plain scan
    tbl.push_back(mk(1, D0, 8'h3F, 8, 0, 0, 2'd0, 1, 0));
    tbl.push_back(mk(0, D1, 8'h06, 8, 0, 0, 2'd1, 1, 0));
    tbl.push_back(mk(0, D2, 8'h5B, 8, 0, 0, 2'd2, 1, 0));
    tbl.push_back(mk(0, D3, 8'h4F, 8, 1, 32'h4F5B063F, 2'd3, 1, 0));
    tbl.push_back(mk(0, IDLE, 8'h00, 8, 0, 0, 2'd0, 0, 0));
    // dwell boundary: 5 cycles captures
    tbl.push_back(mk(1, D0, 8'h11, 5, 0, 0, 2'd0, 1, 0));
    tbl.push_back(mk(0, IDLE, 8'h00, 8, 0, 0, 2'd0, 0, 0));
    tbl.push_back(mk(0, D1, 8'h22, 8, 0, 0, 2'd1, 1, 0));
    tbl.push_back(mk(0, D2, 8'h33, 8, 0, 0, 2'd2, 1, 0));
    tbl.push_back(mk(0, D3, 8'h44, 8, 1, 32'h44332211, 2'd3, 1, 0));
    // dwell boundary: 4 cycles does not capture
    tbl.push_back(mk(1, D0, 8'h55, 4, 0, 0, 2'd0, 1, 0));
    tbl.push_back(mk(0, IDLE, 8'h00, 8, 0, 0, 2'd0, 0, 0));
    tbl.push_back(mk(0, D1, 8'h66, 8, 0, 0, 2'd1, 1, 0));
    tbl.push_back(mk(0, D2, 8'h77, 8, 0, 0, 2'd2, 1, 0));
    tbl.push_back(mk(0, D3, 8'h88, 8, 0, 0, 2'd3, 1, 0));
    // illegal pattern discards partial frame
    tbl.push_back(mk(1, D0, 8'h3F, 8, 0, 0, 2'd0, 1, 0));
    tbl.push_back(mk(0, D1, 8'h06, 8, 0, 0, 2'd1, 1, 0));
    tbl.push_back(mk(0, ILL, 8'h00, 8, 0, 0, 2'd0, 0, 1));
    tbl.push_back(mk(0, D2, 8'h5B, 8, 0, 0, 2'd2, 1, 1));
    tbl.push_back(mk(0, D3, 8'h4F, 8, 0, 0, 2'd3, 1, 1));
    // two-edge digit latency
    tbl.push_back(mk(1, D2, 8'h5B, 2, 0, 0, 2'd2, 1, 0));

    // reset held with random pins
    for (int i = 0; i < 5; i++) begin
      ct = 4'($urandom);
      leds = 8'($urandom);
      @(posedge clk);
      #1;
    end
    check_zero("in_reset");
    reset = 1'b0;
    #1;
    check_zero("after_release");

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      if (tbl[i].fv) exp_q.push_back(tbl[i].fr);
      drive(tbl[i].c, tbl[i].l, tbl[i].hold);
      chk($sformatf("step%0d_digit", i), 32'(digit), 32'(tbl[i].d));
      chk($sformatf("step%0d_digit_valid", i), 32'(digit_valid), 32'(tbl[i].dv));
      chk($sformatf("step%0d_err_count", i), 32'(err_count), 32'(tbl[i].ec));
    end

    // leds toggling every cycle never settles
    do_reset();
    fvb = fv_pulses;
    base = err_pulses;
    foreach (tbl[i]) begin end
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 20; k++) begin
        ct = ~(4'b0001 << d);
        leds = (k % 2 == 1) ? 8'h0F : 8'hF0;
        @(posedge clk);
        #1;
      end
      chk($sformatf("toggle%0d_digit", d), 32'(digit), d);
    end
    drive(IDLE, 8'h00, 8);
    chk("toggle_no_frame", fv_pulses - fvb, 0);
    chk("toggle_no_err", err_pulses - base, 0);

    // err_count saturation over 300 illegal dwells
    do_reset();
    base = err_pulses;
    for (int i = 0; i < 300; i++) begin
      drive((i % 2 == 1) ? ILL2 : ILL, 8'h00, 6);
      if (i == 253) chk("err_count_254", 32'(err_count), 254);
      if (i == 254) chk("err_count_255", 32'(err_count), 255);
    end
    drive(IDLE, 8'h00, 3);
    chk("err_count_saturated", 32'(err_count), 255);
    chk("err_pulses_300", err_pulses - base, 300);

    // idle dwell leaves seen untouched and raises no error
    drive(D0, 8'hAA, 8);
    drive(D1, 8'hBB, 8);
    base = err_pulses;
    drive(IDLE, 8'h00, 20);
    chk("idle_no_err", err_pulses - base, 0);
    chk("idle_digit_valid", 32'(digit_valid), 0);
    drive(D2, 8'hCC, 8);
    exp_q.push_back(32'hDDCCBBAA);
    drive(D3, 8'hDD, 8);
    drive(IDLE, 8'h00, 4);
    chk("idle_err_count", 32'(err_count), 255);

    chk("pending_frames", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
